// File: rtl/branch_resolve_unit.sv
// Branch resolution stage between ID and EX.
// Evaluates the branch condition, forms the branch target, registers the
// outcome for one cycle, flags mispredictions and maintains a 2-bit
// saturating branch history table that feeds predictions back to IF.
module branch_resolve_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned OFF_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  // prediction lookup from IF
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_taken,
  // branch from ID
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_imm,
  input  logic [DATA_W-1:0] br_a,
  input  logic [DATA_W-1:0] br_b,
  input  logic              br_pred,
  input  logic              flush,
  // registered resolution
  output logic              res_valid,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  // performance counters
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  localparam logic [1:0] CTR_MIN   = 2'b00;
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_RESET = 2'b01;

  logic              accept;
  logic              op_known;
  logic              op_taken;
  logic              op_mispred;
  logic              eq;
  logic              lt_s;
  logic              lt_u;
  logic [ADDR_W-1:0] imm_shifted;
  logic [ADDR_W-1:0] target;
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  br_idx;
  logic [1:0]        bht [BHT_DEPTH];
  logic [1:0]        bht_cur;
  logic [1:0]        bht_next;
  logic              bht_upd;
  logic              unused_pc_bits;

  // A branch is accepted only when present and not killed
  assign accept = br_valid & ~flush;

  // Operand comparisons shared by all conditions
  assign eq   = (br_a == br_b);
  assign lt_s = ($signed(br_a) < $signed(br_b));
  assign lt_u = (br_a < br_b);

  // Condition evaluation; reserved encodings resolve not-taken
  always_comb begin
    op_taken = 1'b0;
    op_known = 1'b1;
    case (br_op)
      OP_BEQ:  op_taken = eq;
      OP_BNE:  op_taken = ~eq;
      OP_BLT:  op_taken = lt_s;
      OP_BGE:  op_taken = ~lt_s;
      OP_BLTU: op_taken = lt_u;
      OP_BGEU: op_taken = ~lt_u;
      default: op_known = 1'b0;
    endcase
  end

  assign op_mispred = (op_taken != br_pred);

  // Word offset scaled to bytes; overflow wraps silently
  assign imm_shifted = br_imm << OFF_SHIFT;
  assign target      = br_pc + imm_shifted;

  // BHT indices skip the byte-offset bits of the PC
  assign lk_idx = lk_pc[IDX_W+1:2];
  assign br_idx = br_pc[IDX_W+1:2];

  // Prediction is the MSB of the looked-up counter
  assign lk_taken = bht[lk_idx][1];

  // Saturating next value of the counter addressed by the resolving branch
  always_comb begin
    bht_cur  = bht[br_idx];
    bht_next = bht_cur;
    if (op_taken) begin
      if (bht_cur != CTR_MAX) bht_next = bht_cur + 2'd1;
    end else begin
      if (bht_cur != CTR_MIN) bht_next = bht_cur - 2'd1;
    end
  end

  assign bht_upd = accept & op_known;

  // BHT storage: weakly not-taken after reset, trained on accepted branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht[i] <= CTR_RESET;
      end
    end else if (bht_upd) begin
      bht[br_idx] <= bht_next;
    end
  end

  // Resolution register: one-cycle pulse, payload held between branches
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_taken   <= 1'b0;
      res_target  <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (accept) begin
      res_valid   <= 1'b1;
      res_taken   <= op_taken;
      res_target  <= target;
      mispredict  <= op_mispred;
      redirect_pc <= op_taken ? target : br_pc;
    end else begin
      res_valid   <= 1'b0;
      mispredict  <= 1'b0;
    end
  end

  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (accept) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (op_mispred) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // PC bits outside the BHT index are intentionally ignored
  assign unused_pc_bits = ^{lk_pc[ADDR_W-1:IDX_W+2], lk_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised scoreboard bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lk_pc = '0;
  logic        lk_taken;
  logic        br_valid = 1'b0;
  logic [2:0]  br_op = '0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_imm = '0;
  logic [31:0] br_a = '0;
  logic [31:0] br_b = '0;
  logic        br_pred = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_resolve_unit #(
    .DATA_W(32), .ADDR_W(32), .BHT_DEPTH(16), .OFF_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_pc(lk_pc), .lk_taken(lk_taken),
    .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc), .br_imm(br_imm),
    .br_a(br_a), .br_b(br_b), .br_pred(br_pred), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          tk;
    logic [31:0] tgt;
    bit          mp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: outputs held between branches, counters, BHT
  bit          m_tk;
  logic [31:0] m_tgt, m_rpc, m_bc, m_mc;
  int          m_bht[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tk = 0; m_tgt = '0; m_rpc = '0; m_bc = '0; m_mc = '0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb_;
      3'd5: return sa >= sb_;
      3'd6: return {32'd0, a} < {32'd0, b};
      3'd7: return {32'd0, a} >= {32'd0, b};
      default: return 0;
    endcase
  endfunction

  // One cycle: drive inputs, check the prediction, predict the post-edge outputs
  task automatic step(input bit r, input bit v, input bit fl, input logic [2:0] op,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit pred, input logic [31:0] lk);
    exp_t e;
    bit   tk;
    int   idx;
    @(negedge clk);
    rst = r; br_valid = v; flush = fl; br_op = op; br_pc = pc; br_imm = imm;
    br_a = a; br_b = b; br_pred = pred; lk_pc = lk;
    #1;
    chk("lk_taken", {31'd0, lk_taken}, {31'd0, m_bht[(lk >> 2) % 16] >= 2});
    e.v = 0;
    e.mp = 0;
    if (r) begin
      model_reset();
    end else if (v && !fl) begin
      tk = ref_taken(op, a, b);
      e.v   = 1;
      e.mp  = (tk != pred);
      m_tk  = tk;
      m_tgt = pc + imm * 32'd4;
      m_rpc = tk ? m_tgt : pc;
      m_bc  = m_bc + 1;
      if (e.mp) m_mc = m_mc + 1;
      if (op != 3'd2 && op != 3'd3) begin
        idx = (pc >> 2) % 16;
        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
    end
    e.tk = m_tk; e.tgt = m_tgt; e.rpc = m_rpc; e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [31:0] lk);
    step(0, 0, 0, 3'd0, '0, '0, '0, '0, 0, lk);
  endtask

  // Monitor: compares what the DUT presents after each edge against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_valid", {31'd0, res_valid}, {31'd0, e.v});
        chk("res_taken", {31'd0, res_taken}, {31'd0, e.tk});
        chk("res_target", res_target, e.tgt);
        chk("redirect_pc", redirect_pc, e.rpc);
        if (e.v) chk("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
        chk("branch_cnt", branch_cnt, e.bc);
        chk("mispred_cnt", mispred_cnt, e.mc);
      end
    end
  end

  logic [31:0] pcs [6];
  logic [31:0] vals[6];

  initial begin
    model_reset();
    pcs  = '{32'h40, 32'h80, 32'h100, 32'h3C, 32'h8, 32'hFFFF_FFF0};
    vals = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    // Reset, then every BHT index must predict not-taken
    step(1, 1, 0, 3'd0, 32'h40, 32'd1, 32'd1, 32'd1, 0, 32'h0);
    step(1, 0, 0, 3'd0, '0, '0, '0, '0, 0, 32'h0);
    for (int i = 0; i < 16; i++) idle(32'(i * 4));

    // BEQ equal operands, predicted not-taken
    step(0, 1, 0, 3'd0, 32'h100, 32'h3, 32'd5, 32'd5, 0, 32'h100);
    // Signed vs unsigned compares on 0xFFFFFFFF vs 1
    step(0, 1, 0, 3'd4, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1, 32'h0);
    step(0, 1, 0, 3'd6, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1, 32'h0);
    step(0, 1, 0, 3'd5, 32'h208, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
    step(0, 1, 0, 3'd7, 32'h20C, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
    // Negative offset wrapping below zero
    step(0, 1, 0, 3'd1, 32'h8, 32'hFFFF_FFFC, 32'd1, 32'd2, 1, 32'h0);
    idle(32'h0);

    // Train entry for 0x40 three times; watch 0x40 and its alias 0x80
    step(0, 1, 0, 3'd0, 32'h40, 32'd4, 32'd7, 32'd7, 0, 32'h40);
    step(0, 1, 0, 3'd0, 32'h40, 32'd4, 32'd7, 32'd7, 0, 32'h40);
    step(0, 1, 0, 3'd0, 32'h40, 32'd4, 32'd7, 32'd7, 1, 32'h80);
    idle(32'h40);
    idle(32'h80);

    // Flushed branch, then reserved op with taken prediction
    step(0, 1, 1, 3'd0, 32'h80, 32'd2, 32'd3, 32'd3, 0, 32'h80);
    step(0, 1, 0, 3'd3, 32'h80, 32'd2, 32'd3, 32'd3, 1, 32'h80);
    idle(32'h80);

    // Reset mid-stream while a branch is presented
    step(1, 1, 0, 3'd0, 32'h40, 32'd1, 32'd9, 32'd9, 0, 32'h40);
    idle(32'h40);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      bit          r, v, fl, pr;
      logic [2:0]  op;
      logic [31:0] pc, imm, a, b, lk;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 5) == 0);
      pr  = 1'($urandom);
      op  = 3'($urandom);
      pc  = ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 5)];
      imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(8'($urandom)));
      a   = ($urandom_range(0, 1) == 0) ? $urandom : vals[$urandom_range(0, 5)];
      b   = ($urandom_range(0, 2) == 0) ? a : vals[$urandom_range(0, 5)];
      lk  = ($urandom_range(0, 1) == 0) ? pc : pcs[$urandom_range(0, 5)];
      step(r, v, fl, op, pc, imm, a, b, pr, lk);
    end
    idle(32'h0);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
